// File: rtl/mem_pkg.sv
// Shared definitions for the IM/DM memory responder: sweep FSM states,
// word width and the byte-address to word-index helper.
package mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {
        MS_INIT  = 1'b0,
        MS_READY = 1'b1
    } mem_state_e;

    // Word index of a byte address; the two byte-lane bits are dropped.
    function automatic logic [29:0] idx_of(input logic [31:0] addr);
        return 30'(addr >> 2);
    endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// Post-reset clear sweep: walks every word index once, asserting the clear
// write enable, then parks in READY until the next reset.
module mem_clear_seq
    import mem_pkg::*;
#(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_idx,
    output logic          o_mem_busy
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    mem_state_e    r_state;
    mem_state_e    w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;

    // State and sweep counter registers
    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= MS_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, counter advance and sweep outputs
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_clr_we    = 1'b0;
        o_mem_busy  = 1'b0;
        case (r_state)
            MS_INIT: begin
                o_clr_we   = 1'b1;
                o_mem_busy = 1'b1;
                w_cnt_nxt  = r_cnt + AW'(1);
                if (r_cnt == LAST_IDX) begin
                    w_state_nxt = MS_READY;
                end
            end
            MS_READY: begin
                w_state_nxt = MS_READY;
            end
        endcase
    end

    assign o_clr_idx = r_cnt;

endmodule

// File: rtl/mem_responder.sv
// Unified IM/DM memory responder: word array with registered reads on both
// ports, synchronous DM writes, post-reset clear sweep and a sticky
// out-of-range flag.
// Optional build macro MEM_FWD_EN: forwards a same-edge DM write to IM_out
// (write-first); without it IM reads return the pre-write contents.
module mem_responder
    import mem_pkg::*;
#(
    parameter int                DEPTH     = 1024,
    parameter logic [WORD_W-1:0] CLEAR_VAL = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IM_enable,
    input  logic [31:0]       IM_address,
    output logic [WORD_W-1:0] IM_out,
    input  logic              DM_enable,
    input  logic              DM_write,
    input  logic [31:0]       DM_address,
    input  logic [WORD_W-1:0] DM_in,
    output logic [WORD_W-1:0] DM_out,
    output logic              mem_busy,
    output logic              addr_err
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_im_out;
    logic [WORD_W-1:0] r_dm_out;
    logic              r_addr_err;

    logic              w_clr_we;
    logic [AW-1:0]     w_clr_idx;
    logic              w_busy;
    logic [29:0]       w_im_idx;
    logic [29:0]       w_dm_idx;
    logic              w_im_ok;
    logic              w_dm_ok;
    logic              w_ready;
    logic              w_im_rd;
    logic              w_dm_rd;
    logic              w_dm_wr;
    logic              w_err_hit;
    logic [WORD_W-1:0] w_im_rdata;

    mem_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
        .clk        (clk),
        .rst        (rst),
        .o_clr_we   (w_clr_we),
        .o_clr_idx  (w_clr_idx),
        .o_mem_busy (w_busy)
    );

    assign w_im_idx  = idx_of(IM_address);
    assign w_dm_idx  = idx_of(DM_address);
    assign w_im_ok   = (w_im_idx < DEPTH_W);
    assign w_dm_ok   = (w_dm_idx < DEPTH_W);
    assign w_ready   = ~w_busy;
    assign w_im_rd   = w_ready & IM_enable;
    assign w_dm_rd   = w_ready & DM_enable & ~DM_write;
    assign w_dm_wr   = w_ready & DM_enable & DM_write & w_dm_ok;
    assign w_err_hit = w_ready & ((IM_enable & ~w_im_ok) | (DM_enable & ~w_dm_ok));

`ifdef MEM_FWD_EN
    assign w_im_rdata = (w_dm_wr && (w_dm_idx == w_im_idx)) ? DM_in : r_mem[w_im_idx[AW-1:0]];
`else
    assign w_im_rdata = r_mem[w_im_idx[AW-1:0]];
`endif

    // Storage writes: clear sweep during INIT, DM port writes in READY
    // NOTE: the array has no reset; the post-reset sweep is what initialises it.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_idx] <= CLEAR_VAL;
        end else if (w_dm_wr) begin
            r_mem[w_dm_idx[AW-1:0]] <= DM_in;
        end
    end

    // Registered read ports and sticky out-of-range flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_im_out   <= '0;
            r_dm_out   <= '0;
            r_addr_err <= 1'b0;
        end else begin
            if (w_im_rd) begin
                r_im_out <= w_im_ok ? w_im_rdata : '0;
            end
            if (w_dm_rd) begin
                r_dm_out <= w_dm_ok ? r_mem[w_dm_idx[AW-1:0]] : '0;
            end
            if (w_err_hit) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    assign IM_out   = r_im_out;
    assign DM_out   = r_dm_out;
    assign mem_busy = w_busy;
    assign addr_err = r_addr_err;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder (DEPTH=16). The driver applies one
// request set per cycle, advances a behavioural model and queues the expected
// outputs; the monitor pops and compares after every rising edge.
// Build with MEM_FWD_EN defined to exercise the write-first variant.
module tb_mem_responder;

    localparam int          DEPTH     = 16;
    localparam logic [31:0] CLEAR_VAL = 32'hC1EA_5EED;

    typedef struct {
        logic [31:0] im;
        logic [31:0] dm;
        logic        busy;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        IM_enable;
    logic [31:0] IM_address;
    logic [31:0] IM_out;
    logic        DM_enable;
    logic        DM_write;
    logic [31:0] DM_address;
    logic [31:0] DM_in;
    logic [31:0] DM_out;
    logic        mem_busy;
    logic        addr_err;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    int          m_since_release;
    logic [31:0] m_im;
    logic [31:0] m_dm;
    logic        m_err;

    mem_responder #(.DEPTH(DEPTH), .CLEAR_VAL(CLEAR_VAL)) dut (
        .clk        (clk),
        .rst        (rst),
        .IM_enable  (IM_enable),
        .IM_address (IM_address),
        .IM_out     (IM_out),
        .DM_enable  (DM_enable),
        .DM_write   (DM_write),
        .DM_address (DM_address),
        .DM_in      (DM_in),
        .DM_out     (DM_out),
        .mem_busy   (mem_busy),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One rising edge of the reference: reset, clear sweep, or served requests.
    task automatic model_edge(input logic r, input logic ie, input logic [31:0] ia,
                              input logic de, input logic dw, input logic [31:0] da,
                              input logic [31:0] di);
        logic [31:0] iw;
        logic [31:0] dwd;
        bit          i_ok;
        bit          d_ok;
        iw   = ia >> 2;
        dwd  = da >> 2;
        i_ok = (iw < DEPTH);
        d_ok = (dwd < DEPTH);
        if (!r) begin
            m_since_release = 0;
            m_im  = '0;
            m_dm  = '0;
            m_err = 1'b0;
        end else if (m_since_release < DEPTH) begin
            m_mem[m_since_release] = CLEAR_VAL;
            m_since_release++;
        end else begin
            if (ie) begin
                if (!i_ok) begin
                    m_im  = '0;
                    m_err = 1'b1;
                end else begin
                    m_im = m_mem[iw];
`ifdef MEM_FWD_EN
                    if (de && dw && d_ok && dwd == iw) m_im = di;
`endif
                end
            end
            if (de) begin
                if (!d_ok) m_err = 1'b1;
                if (!dw) m_dm = d_ok ? m_mem[dwd] : '0;
                else if (d_ok) m_mem[dwd] = di;
            end
        end
    endtask

    // Drive one cycle of requests, then model the edge and queue expectations.
    task automatic step(input logic r, input logic ie, input logic [31:0] ia,
                        input logic de, input logic dw, input logic [31:0] da,
                        input logic [31:0] di);
        exp_t e;
        @(negedge clk);
        rst        = r;
        IM_enable  = ie;
        IM_address = ia;
        DM_enable  = de;
        DM_write   = dw;
        DM_address = da;
        DM_in      = di;
        if (!r) begin
            #1;
            check("rst_im_out",   IM_out,          32'h0);
            check("rst_dm_out",   DM_out,          32'h0);
            check("rst_mem_busy", 32'(mem_busy),   32'h1);
            check("rst_addr_err", 32'(addr_err),   32'h0);
        end
        @(posedge clk);
        model_edge(r, ie, ia, de, dw, da, di);
        e.im   = m_im;
        e.dm   = m_dm;
        e.busy = (m_since_release < DEPTH);
        e.err  = m_err;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return 32'($urandom_range(DEPTH * 4, DEPTH * 4 + 63));
        return 32'($urandom_range(0, DEPTH * 4 - 1));
    endfunction

    task automatic rand_step(input logic r);
        step(r, 1'($urandom), rand_addr(), 1'($urandom), 1'($urandom), rand_addr(), $urandom);
    endtask

    // Read every word on both ports (IM ascending, DM descending).
    task automatic readback();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b1, 32'(i * 4), 1'b1, 1'b0, 32'((DEPTH - 1 - i) * 4 + (i % 4)), 32'h0);
        end
    endtask

    // Monitor: compare DUT outputs against the queued expectation after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("IM_out",   IM_out,        e.im);
                check("DM_out",   DM_out,        e.dm);
                check("mem_busy", 32'(mem_busy), 32'(e.busy));
                check("addr_err", 32'(addr_err), 32'(e.err));
            end
        end
    end

    // Driver
    initial begin
        int guard;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;
        m_since_release = 0;
        m_im  = '0;
        m_dm  = '0;
        m_err = 1'b0;
        rst = 1'b0; IM_enable = 1'b0; IM_address = '0;
        DM_enable = 1'b0; DM_write = 1'b0; DM_address = '0; DM_in = '0;

        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Release: sweep runs DEPTH edges; requests during it must be ignored
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 10) step(1'b1, 1'b1, 32'h44, 1'b1, 1'b1, 32'h0C, 32'h0BAD_0BAD);
            else         step(1'b1, 1'b1, 32'(i * 4), 1'b1, 1'b0, 32'(i * 4), 32'h0);
        end
        readback();

        // DM write then read, byte offset ignored
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h13, 32'h0);

        // Same-edge IM read and DM write to one word, then IM read again
        step(1'b1, 1'b1, 32'h20, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
        step(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0);

        // IM hold while disabled, even as the word is overwritten
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h14, 32'hA5A5_A5A5);
        step(1'b1, 1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h14, 32'(i));

        // DM hold while disabled
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h20, 32'h0);

        // Out of range: dropped write, zero read, sticky flag
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hFFFF_0000);
        step(1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
        readback();

        for (int i = 0; i < 300; i++) rand_step(1'b1);
        readback();

        // Reset pulsed at sweep count 7, then a full fresh sweep
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 7; i++) rand_step(1'b1);
        step(1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 32'h8, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < DEPTH; i++) rand_step(1'b1);
        readback();
        step(1'b1, 1'b1, 32'h48, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 32'h4, 1'b1, 1'b0, 32'h3C, 32'h0);
        for (int i = 0; i < 40; i++) rand_step(1'b1);
        readback();

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Unified instruction/data memory responder that answers the CPU's IM and DM request ports. It is the memory end of the same IM/DM interface the CPU drives, and sits beside `CPU` in simulation and synthesis tops. It provides a word-organised array with one-cycle registered reads on both ports and synchronous writes on the DM port. After every reset it runs a clear sweep, and it flags out-of-range accesses.

## Interface
- `DEPTH`, 1024: number of 32-bit words; power of two, at least 4.
- `CLEAR_VAL`, 32'h0000_0000: value written into every word by the post-reset sweep.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `IM_enable`  in  1  instruction read request.
- `IM_address`  in  32  instruction byte address.
- `IM_out`  out  32  instruction read data, registered.
- `DM_enable`  in  1  data access request.
- `DM_write`  in  1  1 = write, 0 = read; qualified by `DM_enable`.
- `DM_address`  in  32  data byte address.
- `DM_in`  in  32  data write value.
- `DM_out`  out  32  data read data, registered.
- `mem_busy`  out  1  high while the clear sweep runs.
- `addr_err`  out  1  sticky out-of-range flag.

## Operation
- Word index = `address[31:2]`. Bits [1:0] are ignored.
- An address is in range when `address[31:2] < DEPTH`.
- FSM has two states: INIT and READY.
- **INIT** (entered on reset):
  - sweep counter writes `CLEAR_VAL` to word `cnt`, then increments `cnt`, one word per cycle;
  - after word DEPTH-1 is written, moves to READY;
  - all requests are ignored: no write, outputs hold 0, `addr_err` is not updated.
- **READY**, IM port: `IM_enable`=1 with an in-range address loads `IM_out` with `mem[idx]` at the next edge.
- **READY**, DM read: `DM_enable`=1, `DM_write`=0, in range → `DM_out` = `mem[idx]` at the next edge.
- **READY**, DM write: `DM_enable`=1, `DM_write`=1, in range → `mem[idx]` = `DM_in` at the edge. `DM_out` holds.
- Enable low: the corresponding output holds its last value.
- Out of range:
  - a read returns 0 on that output;
  - a write is dropped;
  - `addr_err` is set and stays set until reset.
- Simultaneous IM read and DM write to the same word: IM returns the pre-write contents (read-first), unless `MEM_FWD_EN` is defined.
- Simultaneous IM and DM reads, same or different word: both are served in the same cycle; there is no arbitration and no stall.
- Reset asserted mid-sweep or mid-access:
  - immediately forces INIT, `cnt`=0, `IM_out`=`DM_out`=0, `mem_busy`=1, `addr_err`=0;
  - the sweep restarts from word 0.

## Timing
- Reset values: `IM_out`=0, `DM_out`=0, `mem_busy`=1, `addr_err`=0, state INIT, `cnt`=0.
- Sweep length: `mem_busy` is high for exactly DEPTH rising edges after reset deassertion. It falls after the edge that writes word DEPTH-1.
- The first request honoured is the one presented with `mem_busy`=0 at an edge.
- Read latency: 1 cycle. A request sampled at edge N has its data valid after edge N, usable at edge N+1.
- Write latency: 0 cycles. A write at edge N is visible to a read sampled at edge N+1.
- `addr_err` rises after the edge that samples the offending request.
- Back-to-back requests on either port are allowed every cycle.

## Configuration
- `MEM_FWD_EN` defined: an IM read and a DM write to the same in-range word at the same edge return `DM_in` on `IM_out` (write-first forwarding).
- `MEM_FWD_EN` undefined: `IM_out` returns the old contents. No forwarding mux is built.
- DM-port behaviour is identical in both builds.

## Structure
- Shared package `mem_pkg` holds:
  - the state enum `mem_state_e` {`MS_INIT`, `MS_READY`};
  - the `WORD_W`=32 constant;
  - an `idx_of(addr)` function returning `addr[31:2]`.
- Sub-module `mem_clear_seq`: owns the sweep counter and INIT→READY FSM; outputs the write enable, clear index and `mem_busy`.
- The storage array and both port registers stay in `mem_responder`.

## Test plan
- Reset release with DEPTH=16:
  - `mem_busy`=1 for 16 edges, then 0;
  - IM reads of words 0..15 return `CLEAR_VAL`;
  - a DM write presented during INIT leaves its word at `CLEAR_VAL`.
- DM write then read:
  - write 32'hDEAD_BEEF at address 0x10, then read 0x10 → `DM_out`=32'hDEAD_BEEF one cycle later;
  - read 0x13 returns the same word.
- Same-cycle IM read and DM write of 32'h1234_5678 to 0x20, prior contents 0:
  - without `MEM_FWD_EN` → `IM_out`=0;
  - with it → `IM_out`=32'h1234_5678;
  - IM read next cycle returns 32'h1234_5678 in both builds.
- Out of range with DEPTH=16:
  - DM write to 0x40 → no word changes, `addr_err`=1;
  - IM read of 0x44 → `IM_out`=0;
  - `addr_err` stays 1 through later legal accesses.
- Enable low: with `IM_enable`=0 for 3 cycles after a read of 32'hA5A5_A5A5, `IM_out` holds 32'hA5A5_A5A5.
- Reset pulsed at sweep count 7:
  - outputs return to 0, `addr_err`=0;
  - `mem_busy` stays high for a full 16 edges after the new release.
